systolic_operand_feeder: RTL
============================

# systolic_operand_feeder

Buffers one A operand tile and one B operand tile, then replays them as one vector per cycle into the systolic input controller. The feeder drives the controller's enable, load, data_flow, A and B inputs. It sits directly upstream of the input controller. It sequences weight preload in WS mode, streams compute vectors, and appends a zero flush so the skewed array drains cleanly.

## Interface
- DATA_WIDTH, 8, operand element width (signed)
- ROWS, 4, array rows = elements per A vector
- COLS, 4, array columns = elements per B vector
- K_MAX, 8, buffer depth in vectors per operand; must be ≥ ROWS
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_a_en  in  1  write A buffer entry wr_addr
- wr_b_en  in  1  write B buffer entry wr_addr
- wr_addr  in  $clog2(K_MAX)  buffer entry index
- wr_a_data  in  DATA_WIDTH*ROWS  A vector, element r at bits [(r+1)*DATA_WIDTH-1 -: DATA_WIDTH]
- wr_b_data  in  DATA_WIDTH*COLS  B vector, same packing per column
- start  in  1  begin a run (sampled only in IDLE)
- mode  in  1  0 = OS, 1 = WS; sampled with start
- k_len  in  $clog2(K_MAX+1)  vectors to stream; sampled with start
- busy  out  1  run in progress
- done  out  1  one-cycle end-of-run pulse
- err  out  1  one-cycle pulse: illegal start
- ctl_enable, ctl_load, ctl_data_flow  out  1 each  to controller enable/load/data_flow
- ctl_A  out  DATA_WIDTH*ROWS  to controller A
- ctl_B  out  DATA_WIDTH*COLS  to controller B

## Operation
- All outputs are registered. Reset value of every output is 0. State resets to IDLE. Buffer storage is not reset; its contents are undefined after reset.
- Writes are accepted only when busy=0. Writes while busy are ignored. wr_a_en and wr_b_en may both be high in the same cycle; both buffers are then written at wr_addr. wr_addr ≥ K_MAX is ignored.
- start in IDLE with k_len = 0 or k_len > K_MAX: err pulses for 1 cycle and the FSM stays in IDLE. start outside IDLE is ignored.
- States and transitions:
  - IDLE: exits on a legal start. mode=1 goes to WLOAD; mode=0 goes to STREAM.
  - WLOAD (WS only), ROWS cycles: ctl_load=1, ctl_B = B[i] for i = 0..ROWS-1, ctl_A = 0. Then goes to STREAM.
  - STREAM, k_len cycles: ctl_load=0, ctl_A = A[i]. ctl_B = B[i] in OS mode and 0 in WS mode. Then goes to FLUSH.
  - FLUSH, ROWS+COLS-1 cycles: ctl_A = ctl_B = 0, ctl_load=0. Then goes to DONE.
  - DONE, 1 cycle: done=1, busy=0, ctl_enable=0. Then goes to IDLE.
- ctl_enable=1 and busy=1 in WLOAD, STREAM and FLUSH. ctl_data_flow holds the sampled mode from the start edge through DONE, and returns to 0 in IDLE.
- Data is moved unchanged (no arithmetic); element packing is preserved.

## Timing
- Zero bubble: the edge that samples a legal start also loads the first vector into the output registers. That vector is visible in the following cycle.
- The index counter increments every cycle and resets to 0 on each state transition.
- OS run: k_len + ROWS + COLS − 1 enable cycles, then 1 done cycle.
- WS run: ROWS + k_len + ROWS + COLS − 1 enable cycles, then 1 done cycle.
- start asserted in the DONE cycle is ignored. A new start is accepted no earlier than the first IDLE cycle.
- Asserting rst_n low mid-run immediately clears all outputs, including ctl_enable, and returns the FSM to IDLE. No done pulse is issued.
- There is no back-pressure; the downstream controller consumes one vector per cycle.

## Structure
- Shared package systolic_pkg holds:
  - the state enum (IDLE, WLOAD, STREAM, FLUSH, DONE);
  - DF_OS = 1'b0 and DF_WS = 1'b1;
  - the flush-length function (ROWS+COLS-1).
- Sub-module operand_buffer: K_MAX × width register file with 1 synchronous write port and 1 asynchronous read port, instantiated once for A and once for B. The FSM, counter and output registers live in the top.

## Test plan
- Reset check: rst_n low → all outputs 0. Release, then write A[0..2] and B[0..2] and start mode=0, k_len=3 → ctl_A/ctl_B show A[0], A[1], A[2] / B[0], B[1], B[2] on 3 consecutive cycles. Then 7 zero cycles with ctl_enable=1, then done=1 for 1 cycle.
- WS run: B[0..3] = 0x10, 0x20, 0x30, 0x40 (all elements) and start mode=1, k_len=2 → 4 cycles with ctl_load=1 carrying those weights with ctl_A=0. Then 2 cycles of A[0], A[1] with ctl_B=0, then 7 flush cycles, then done. ctl_data_flow=1 throughout.
- Illegal start: start with k_len=0, then with k_len=9 → err pulses each time, busy stays 0, ctl_enable stays 0.
- Busy protection: during a run, write A[0]=0xFF and pulse start → no effect. A rerun with k_len=1 streams the original A[0].
- Reset mid-run: drop rst_n during STREAM cycle 2 → outputs 0 asynchronously with no done pulse. After reset, a fresh start runs normally.
- Back-to-back: start held high continuously → the second run begins in the cycle after the DONE cycle.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic operand feeder.
//   state_t   : feeder FSM states
//   DF_OS/WS  : data_flow encodings driven to the input controller
//   flush_len : zero vectors needed to drain a ROWS x COLS skewed array
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WLOAD,
    STREAM,
    FLUSH,
    DONE
  } state_t;

  localparam logic DF_OS = 1'b0;
  localparam logic DF_WS = 1'b1;

  function automatic int flush_len(input int rows, input int cols);
    return rows + cols - 1;
  endfunction

endpackage

// File: rtl/operand_buffer.sv
// Operand vector store: DEPTH x WIDTH register file.
// Ports:
//   clk      - write clock
//   wr_en    - write enable (addresses >= DEPTH are dropped)
//   wr_addr  - write entry
//   wr_data  - write vector
//   rd_addr  - read entry (asynchronous read)
//   rd_data  - read vector
// Storage is intentionally not reset.
module operand_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en && (int'(wr_addr) < DEPTH)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/systolic_operand_feeder.sv
// Replays a buffered A tile and B tile into the systolic input controller,
// one vector per cycle: optional weight preload (WS), compute stream, then a
// zero flush that drains the skewed array.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   wr_a_en, wr_b_en, wr_addr  - buffer write strobes and entry index
//   wr_a_data, wr_b_data       - vectors written into the A / B buffers
//   start, mode, k_len         - run request, dataflow (0 OS, 1 WS), length
//   busy, done, err            - run status, end-of-run pulse, bad-start pulse
//   ctl_enable, ctl_load,
//   ctl_data_flow, ctl_A, ctl_B - registered drive of the input controller
module systolic_operand_feeder
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int K_MAX      = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_a_en,
  input  logic                         wr_b_en,
  input  logic [$clog2(K_MAX)-1:0]     wr_addr,
  input  logic [DATA_WIDTH*ROWS-1:0]   wr_a_data,
  input  logic [DATA_WIDTH*COLS-1:0]   wr_b_data,
  input  logic                         start,
  input  logic                         mode,
  input  logic [$clog2(K_MAX+1)-1:0]   k_len,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic                         ctl_enable,
  output logic                         ctl_load,
  output logic                         ctl_data_flow,
  output logic [DATA_WIDTH*ROWS-1:0]   ctl_A,
  output logic [DATA_WIDTH*COLS-1:0]   ctl_B
);

  localparam int AW        = $clog2(K_MAX);
  localparam int KW        = $clog2(K_MAX + 1);
  localparam int FLUSH_LEN = flush_len(ROWS, COLS);
  localparam int CNT_MAX   = (K_MAX > FLUSH_LEN) ? K_MAX : FLUSH_LEN;
  localparam int CW        = $clog2(CNT_MAX + 1);
  localparam int AWID      = DATA_WIDTH * ROWS;
  localparam int BWID      = DATA_WIDTH * COLS;

  state_t          state, state_n;
  logic [CW-1:0]   idx, idx_n;
  logic            mode_r, mode_n;
  logic [KW-1:0]   klen_r, klen_n;
  logic            err_n;
  logic            run_n;
  logic [AWID-1:0] rd_a;
  logic [BWID-1:0] rd_b;

  // Buffers are frozen for the whole run so the replayed tile is stable.
  operand_buffer #(.WIDTH(AWID), .DEPTH(K_MAX), .AW(AW)) u_buf_a (
    .clk     (clk),
    .wr_en   (wr_a_en && !busy),
    .wr_addr (wr_addr),
    .wr_data (wr_a_data),
    .rd_addr (idx_n[AW-1:0]),
    .rd_data (rd_a)
  );

  operand_buffer #(.WIDTH(BWID), .DEPTH(K_MAX), .AW(AW)) u_buf_b (
    .clk     (clk),
    .wr_en   (wr_b_en && !busy),
    .wr_addr (wr_addr),
    .wr_data (wr_b_data),
    .rd_addr (idx_n[AW-1:0]),
    .rd_data (rd_b)
  );

  // 'state' and 'idx' describe the vector currently on the outputs; the next
  // state/index select the vector loaded at the coming edge, which is what
  // lets the start edge already present the first vector.
  always_comb begin
    state_n = state;
    idx_n   = idx + 1'b1;
    mode_n  = mode_r;
    klen_n  = klen_r;
    err_n   = 1'b0;
    unique case (state)
      IDLE: begin
        idx_n = '0;
        if (start) begin
          if ((k_len == '0) || (int'(k_len) > K_MAX)) begin
            err_n = 1'b1;
          end else begin
            state_n = (mode == DF_WS) ? WLOAD : STREAM;
            mode_n  = mode;
            klen_n  = k_len;
          end
        end
      end
      WLOAD: begin
        if (int'(idx) == ROWS - 1) begin
          state_n = STREAM;
          idx_n   = '0;
        end
      end
      STREAM: begin
        if (int'(idx) == int'(klen_r) - 1) begin
          state_n = FLUSH;
          idx_n   = '0;
        end
      end
      FLUSH: begin
        if (int'(idx) == FLUSH_LEN - 1) begin
          state_n = DONE;
          idx_n   = '0;
        end
      end
      DONE: begin
        state_n = IDLE;
        idx_n   = '0;
      end
      default: begin
        state_n = IDLE;
        idx_n   = '0;
      end
    endcase
  end

  assign run_n = (state_n == WLOAD) || (state_n == STREAM) || (state_n == FLUSH);

  // Output register stage: everything seen by the controller is registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      idx           <= '0;
      mode_r        <= DF_OS;
      klen_r        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      ctl_enable    <= 1'b0;
      ctl_load      <= 1'b0;
      ctl_data_flow <= DF_OS;
      ctl_A         <= '0;
      ctl_B         <= '0;
    end else begin
      state         <= state_n;
      idx           <= idx_n;
      mode_r        <= mode_n;
      klen_r        <= klen_n;
      busy          <= run_n;
      done          <= (state_n == DONE);
      err           <= err_n;
      ctl_enable    <= run_n;
      ctl_load      <= (state_n == WLOAD);
      ctl_data_flow <= (state_n == IDLE) ? DF_OS : mode_n;
      ctl_A         <= (state_n == STREAM) ? rd_a : '0;
      // B carries weights during preload, and streams only in OS mode.
      ctl_B         <= ((state_n == WLOAD) || ((state_n == STREAM) && (mode_n == DF_OS)))
                       ? rd_b : '0;
    end
  end

endmodule
